ifu_fetch_queue: RTL and testbench

//  Instruction fetch stage of the minirv NPC, directly upstream of decode. Issues word

---
 rtl/ifu_fetch_queue.sv | 141 ++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch stage: single-outstanding imem requests feeding a small in-order queue toward decode.
// Optional build macro IFU_PERF_EN adds perf_fetch_cnt / perf_flush_cnt counter ports.
`timescale 1ns/1ps
module ifu_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
`ifdef IFU_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [2:0]  id_funct3
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   req_addr_reg, req_addr_next;
  logic          discard_reg, discard_next;
  logic [AW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   pc_mem   [QDEPTH];
  logic [31:0]   inst_mem [QDEPTH];

  logic [31:0] redir_aligned;
  logic        push, pop;

  assign redir_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign id_valid      = (count_reg != '0);
  // Redirect kills both the landing response and any decode handshake in the same cycle.
  assign push = (state_reg == WAIT) && imem_resp_valid && !discard_reg && !redirect_valid;
  assign pop  = id_valid && id_ready && !redirect_valid;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_addr_next = req_addr_reg;
    discard_next  = discard_reg;
    unique case (state_reg)
      IDLE: begin
        if (redirect_valid || (count_reg < QDEPTH_C)) begin
          state_next    = REQ;
          req_addr_next = redirect_valid ? redir_aligned : fetch_pc_reg;
        end
      end
      REQ: begin
        // Address stays frozen until accepted; a redirect only marks the answer stale.
        if (imem_req_ready) state_next = WAIT;
        if (redirect_valid) discard_next = 1'b1;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_next   = IDLE;
          discard_next = 1'b0;
          if (push) fetch_pc_next = fetch_pc_reg + 32'd4;
        end else if (redirect_valid) begin
          discard_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (redirect_valid) fetch_pc_next = redir_aligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= RESET_PC;
      discard_reg  <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_addr_reg <= req_addr_next;
      discard_reg  <= discard_next;
      if (redirect_valid) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + AW'(1);
        if (pop)  head_reg <= head_reg + AW'(1);
        unique case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Queue storage needs no reset: entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_reg]   <= fetch_pc_reg;
      inst_mem[tail_reg] <= imem_resp_data;
    end
  end

  assign imem_req_valid = (state_reg == REQ);
  assign imem_req_addr  = req_addr_reg;
  assign id_pc          = pc_mem[head_reg];
  assign id_inst        = inst_mem[head_reg];
  assign id_opcode      = id_inst[6:0];
  assign id_funct3      = id_inst[14:12];

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (id_valid && id_ready) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid)       perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Self-checking bench for ifu_fetch_queue: table-driven drain checks plus directed redirect/wrap/reset sequences.
`timescale 1ns/1ps
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  ifu_fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .id_opcode(id_opcode),
`ifdef IFU_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .id_funct3(id_funct3)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          ready_en = 1'b1;
  bit          pending  = 1'b0;
  logic [31:0] pend_addr;

  typedef struct {
    int          hold;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  op;
    logic [2:0]  f3;
  } vec_t;
  vec_t vecs[5];

  // Memory contents: (addr << 10) ^ 0x13, so funct3 tracks address bits [4:2].
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 10) ^ 32'h0000_0013;
  endfunction

  // Memory responder: answers each accepted request exactly one cycle later.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      if (pending) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr);
        pending         = 1'b0;
      end
      imem_req_ready = ready_en;
      if (imem_req_valid && ready_en && !rst) begin
        pending   = 1'b1;
        pend_addr = imem_req_addr;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic wait_id(input string name);
    int i = 0;
    while (!id_valid && i < 100) begin step(); i++; end
    chk({name, " id_valid"}, 32'(id_valid), 32'd1);
  endtask

  task automatic pop_check(input string name, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [6:0] op, input logic [2:0] f3);
    wait_id(name);
    chk({name, " id_pc"}, id_pc, pc);
    chk({name, " id_inst"}, id_inst, inst);
    chk({name, " id_opcode"}, 32'(id_opcode), 32'(op));
    chk({name, " id_funct3"}, 32'(id_funct3), 32'(f3));
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
  endtask

  task automatic wait_req(input string name, output logic [31:0] addr);
    int i = 0;
    while (!(imem_req_valid && imem_req_ready) && i < 100) begin step(); i++; end
    chk({name, " accepted"}, 32'(imem_req_valid && imem_req_ready), 32'd1);
    addr = imem_req_addr;
    step();
  endtask

  task automatic wait_stall(input string name);
    int i = 0;
    id_ready = 1'b1;
    while (!(imem_req_valid && !imem_req_ready) && i < 100) begin step(); i++; end
    id_ready = 1'b0;
    chk({name, " stalled req"}, 32'(imem_req_valid && !imem_req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] a0;
    int          i;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;

    vecs[0] = '{0, 32'h8000_0000, 32'h0000_0013, 7'h13, 3'd0};
    vecs[1] = '{0, 32'h8000_0004, 32'h0000_1013, 7'h13, 3'd1};
    vecs[2] = '{2, 32'h8000_0008, 32'h0000_2013, 7'h13, 3'd2};
    vecs[3] = '{0, 32'h8000_000C, 32'h0000_3013, 7'h13, 3'd3};
    vecs[4] = '{1, 32'h8000_0010, 32'h0000_4013, 7'h13, 3'd4};

    repeat (2) step();
    chk("reset req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset id_valid", 32'(id_valid), 32'd0);
    rst = 1'b0;

    // First fetch after reset, then in-order drain from the vector table.
    wait_req("first req", a);
    chk("first req_addr", a, 32'h8000_0000);
    for (int k = 0; k < 5; k++) begin
      repeat (vecs[k].hold) step();
      pop_check($sformatf("vec%0d", k), vecs[k].pc, vecs[k].inst, vecs[k].op, vecs[k].f3);
    end

    // Decode stalled: queue holds exactly two entries and fetch stops.
    repeat (10) step();
    chk("full req_valid", 32'(imem_req_valid), 32'd0);
    chk("full id_valid", 32'(id_valid), 32'd1);
    chk("full head pc", id_pc, 32'h8000_0014);
    id_ready = 1'b1; step(); id_ready = 1'b0;
    chk("full second pc", id_pc, 32'h8000_0018);
    id_ready = 1'b1; step(); id_ready = 1'b0;
    chk("full drained", 32'(id_valid), 32'd0);
    pop_check("refill", 32'h8000_001C, 32'h0000_7013, 7'h13, 3'd7);

    // Stalled request survives a redirect; its response is discarded.
    ready_en = 1'b0;
    wait_stall("t3");
    a0 = imem_req_addr;
    step();
    chk("t3 addr stable 1", imem_req_addr, a0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    step();
    redirect_valid = 1'b0;
    chk("t3 addr stable 2", imem_req_addr, a0);
    chk("t3 valid held", 32'(imem_req_valid), 32'd1);
    chk("t3 flushed", 32'(id_valid), 32'd0);
    step();
    chk("t3 addr stable 3", imem_req_addr, a0);
    ready_en = 1'b1;
    wait_req("t3 old", a);
    chk("t3 old addr", a, a0);
    wait_req("t3 new", a);
    chk("t3 new addr", a, 32'h8000_0100);
    wait_id("t3");
    chk("t3 id_pc", id_pc, 32'h8000_0100);
    chk("t3 id_inst", id_inst, 32'h0004_0013);

    // Redirect coincides with a response and a pop: everything dropped, no discard left.
    i = 0;
    while (!imem_resp_valid && i < 100) begin step(); i++; end
    chk("t4 resp seen", 32'(imem_resp_valid), 32'd1);
    chk("t4 head valid", 32'(id_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    id_ready       = 1'b1;
    step();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    chk("t4 flushed", 32'(id_valid), 32'd0);
    step();
    chk("t4 req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4 req_addr", imem_req_addr, 32'h8000_0200);
    step();
    step();
    chk("t4 id_valid", 32'(id_valid), 32'd1);
    chk("t4 id_pc", id_pc, 32'h8000_0200);
    chk("t4 id_inst", id_inst, 32'h0008_0013);

    // Address wrap; low redirect bits are ignored.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    pop_check("wrap top", 32'hFFFF_FFFC, 32'hFFFF_F013, 7'h13, 3'd7);
    pop_check("wrap zero", 32'h0000_0000, 32'h0000_0013, 7'h13, 3'd0);

    // Asynchronous reset in the middle of a pending request.
    ready_en = 1'b0;
    wait_stall("t6");
    #2;
    rst = 1'b1;
    #1;
    chk("async rst req_valid", 32'(imem_req_valid), 32'd0);
    chk("async rst id_valid", 32'(id_valid), 32'd0);
`ifdef IFU_PERF_EN
    chk("async rst perf_fetch", perf_fetch_cnt, 32'd0);
    chk("async rst perf_flush", perf_flush_cnt, 32'd0);
`endif
    step();
    step();
    rst      = 1'b0;
    ready_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pop_check($sformatf("post rst %0d", k), vecs[k].pc, vecs[k].inst, vecs[k].op, vecs[k].f3);
    end
    for (int k = 0; k < 2; k++) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0400;
      step();
      redirect_valid = 1'b0;
      step();
    end
`ifdef IFU_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'd5);
    chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif
    wait_id("post redirect");
    chk("post redirect pc", id_pc, 32'h8000_0400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
